// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate L1 data cache controller, 32 lines x 256 bits.
// Misses stall the pipeline while the victim is evicted and the line is refilled over mem_*.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p1_req_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;
  typedef struct packed {
    logic [21:0] tag;
    logic [4:0]  idx;
  } req_t;

  state_t              state_q;
  req_t                req, req_q;
  logic [2:0]          word;
  logic [31:0][21:0]   tag_q;
  logic [31:0][255:0]  data_q;
  logic [31:0]         valid_q, dirty_q;
  logic                hit, idle_acc, st_hit;
  logic                mem_enable_q, mem_write_q;
  logic [31:0]         mem_addr_q;
  logic [255:0]        mem_data_q;
  logic                unused_byte;

  assign req         = '{tag: p1_addr_i[31:10], idx: p1_addr_i[9:5]};
  assign word        = p1_addr_i[4:2];
  assign unused_byte = ^p1_addr_i[1:0];

  assign hit      = valid_q[req.idx] && (tag_q[req.idx] == req.tag);
  assign idle_acc = (state_q == IDLE) && p1_req_i;
  assign st_hit   = idle_acc && p1_write_i && hit;

  assign p1_stall_o = (state_q != IDLE) || (p1_req_i && !hit);
  assign p1_data_o  = (idle_acc && !p1_write_i && hit) ?
                      data_q[req.idx][{word, 5'd0} +: 32] : '0;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // Miss address is latched so a dropped request still completes its refill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      req_q        <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_hit) dirty_q[req.idx] <= 1'b1;
          if (p1_req_i && !hit) begin
            req_q   <= req;
            state_q <= MISS;
          end
        end
        MISS: begin
          mem_enable_q <= 1'b1;
          if (valid_q[req_q.idx] && dirty_q[req_q.idx]) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_q[req_q.idx], req_q.idx, 5'd0};
            mem_data_q  <= data_q[req_q.idx];
            state_q     <= WRITEBACK;
          end else begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= {req_q, 5'd0};
            state_q     <= READMISS;
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          mem_write_q <= 1'b0;
          mem_addr_q  <= {req_q, 5'd0};
          mem_data_q  <= '0;
          state_q     <= READMISS;
        end
        READMISS: if (mem_ack_i) begin
          valid_q[req_q.idx] <= 1'b1;
          dirty_q[req_q.idx] <= 1'b0;
          mem_enable_q       <= 1'b0;
          mem_addr_q         <= '0;
          state_q            <= READMISSOK;
        end
        READMISSOK: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q gates them.
  always_ff @(posedge clk_i) begin
    if (st_hit) data_q[req.idx][{word, 5'd0} +: 32] <= p1_data_i;
    if (state_q == READMISS && mem_ack_i) begin
      data_q[req_q.idx] <= mem_data_i;
      tag_q[req_q.idx]  <= req_q.tag;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a reference cache model queues expected responses
// and memory transactions; monitors compare them against the DUT as they appear.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         p1_req_i = 1'b0, p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit wr; logic [31:0] data; int stall; } resp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } memx_t;

  resp_t        resp_q[$];
  memx_t        memx_q[$];
  logic [255:0] mem_img [logic [31:0]];
  bit           cv[32], cd[32];
  logic [21:0]  ct[32];
  logic [255:0] cline[32];
  int           checks = 0, errors = 0;
  int           lat_cfg = 1;

  function automatic logic [255:0] line_init(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h9E37_0000 + w);
    return l;
  endfunction

  function automatic logic [255:0] rd_line(input logic [31:0] la);
    if (mem_img.exists(la)) return mem_img[la];
    return line_init(la);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bail(input string nm);
    checks++; errors++;
    $display("FAIL %s: timed out", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench aborted");
  endtask

  // Model of a miss: optional eviction of the dirty victim, then a refill of the line.
  task automatic model_fill(input logic [31:0] a, output bit wb);
    logic [4:0]  idx;
    logic [31:0] va;
    idx = a[9:5];
    wb  = cv[idx] && cd[idx];
    if (wb) begin
      va = {ct[idx], idx, 5'd0};
      memx_q.push_back('{1'b1, va, cline[idx]});
      mem_img[va] = cline[idx];
    end
    memx_q.push_back('{1'b0, {a[31:5], 5'd0}, '0});
    cline[idx] = rd_line({a[31:5], 5'd0});
    ct[idx] = a[31:10]; cv[idx] = 1'b1; cd[idx] = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit drop_req);
    logic [4:0] idx;
    int  w, L, exp_st, k, drop_at;
    bit  hit, wb, done, drop;
    idx = a[9:5]; w = int'(a[4:2]);
    hit = cv[idx] && (ct[idx] == a[31:10]);
    L = $urandom_range(1, 4);
    lat_cfg = L;
    exp_st = 0;
    if (!hit) begin
      model_fill(a, wb);
      exp_st = 3 + L + (wb ? L : 0);
    end
    drop = drop_req && !hit;
    drop_at = $urandom_range(1, 3);
    if (!drop) begin
      if (wr) begin cline[idx][w*32 +: 32] = d; cd[idx] = 1'b1; end
      resp_q.push_back('{wr, wr ? 32'h0 : cline[idx][w*32 +: 32], exp_st});
    end
    @(posedge clk_i); #1;
    p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
    done = 1'b0; k = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk_i);
      if (!p1_stall_o) done = 1'b1;
      else begin
        k++;
        if (drop && k == drop_at) begin
          @(posedge clk_i); #1;
          p1_req_i = 1'b0;
          for (int j = 0; j < 400 && p1_stall_o; j++) @(negedge clk_i);
          if (p1_stall_o) bail("drop_return_idle");
          return;
        end
      end
    end
    if (!done) bail("access_complete");
    @(posedge clk_i); #1;
    p1_req_i = 1'b0;
  endtask

  task automatic reset_in_readmiss(input logic [31:0] a);
    bit wb, seen;
    lat_cfg = 40;
    model_fill(a, wb);
    @(posedge clk_i); #1;
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = a; p1_data_i = '0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk_i);
      seen = mem_enable_o && !mem_write_o;
    end
    if (!seen) bail("reach_readmiss");
    #1;
    rst_i = 1'b0; p1_req_i = 1'b0;
    #1;
    chk("rst_mem_enable", mem_enable_o, 0);
    chk("rst_stall", p1_stall_o, 0);
    for (int i = 0; i < 32; i++) begin cv[i] = 1'b0; cd[i] = 1'b0; end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Memory responder: acks after lat_cfg cycles of mem_enable_o.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0; mem_data_i = '0;
      if (rst_i && mem_enable_o) begin
        cnt++;
        if (cnt >= lat_cfg) begin
          mem_ack_i = 1'b1;
          if (!mem_write_o) mem_data_i = rd_line(mem_addr_o);
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // Monitor: pipeline responses and memory transactions against the scoreboards.
  initial begin
    int    stall_cnt;
    bit    en_d, ack_d;
    resp_t r;
    memx_t m;
    stall_cnt = 0; en_d = 1'b0; ack_d = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        stall_cnt = 0; en_d = 1'b0; ack_d = 1'b0;
      end else begin
        if (p1_req_i) begin
          if (p1_stall_o) begin
            stall_cnt++;
            chk("stall_data_zero", p1_data_o, 0);
          end else if (resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got addr %0h with nothing expected", p1_addr_i);
          end else begin
            r = resp_q.pop_front();
            chk(r.wr ? "store_data_zero" : "load_data", p1_data_o, r.data);
            chk("stall_cycles", stall_cnt, r.stall);
            stall_cnt = 0;
          end
        end else stall_cnt = 0;
        if (mem_enable_o && (!en_d || ack_d)) begin
          if (memx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem: got addr %0h with nothing expected", mem_addr_o);
          end else begin
            m = memx_q.pop_front();
            chk("mem_write", mem_write_o, m.wr);
            chk("mem_addr", mem_addr_o, m.addr);
            if (m.wr) chk("mem_wb_data", mem_data_o, m.data);
          end
        end else if (!mem_enable_o) begin
          chk("mem_addr_idle", mem_addr_o, 0);
          chk("mem_data_idle", mem_data_o, 0);
        end
        en_d = mem_enable_o; ack_d = mem_ack_i;
      end
    end
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    l = line_init(32'h40);
    l[63:32] = 32'hDEADBEEF;
    mem_img[32'h40] = l;
    for (int i = 0; i < 32; i++) begin cv[i] = 1'b0; cd[i] = 1'b0; ct[i] = '0; cline[i] = '0; end

    #12;
    chk("reset_stall", p1_stall_o, 0);
    chk("reset_mem_enable", mem_enable_o, 0);
    chk("reset_data", p1_data_o, 0);
    @(negedge clk_i); rst_i = 1'b1;

    access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    access(1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0);
    access(1'b0, 32'h0000_0044, 32'h0, 1'b0);
    access(1'b0, 32'h0000_0444, 32'h0, 1'b0);
    access(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 1'b0);
    access(1'b0, 32'h0000_0080, 32'h0, 1'b0);
    access(1'b0, 32'h0000_0480, 32'h0, 1'b0);
    access(1'b1, 32'h0000_04C4, 32'h0BAD_F00D, 1'b0);
    reset_in_readmiss(32'h0000_08C0);
    access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    access(1'b0, 32'h0000_0100, 32'h0, 1'b1);
    access(1'b0, 32'h0000_0104, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 15) == 0);
    end

    repeat (5) @(negedge clk_i);
    chk("resp_q_drained", resp_q.size(), 0);
    chk("memx_q_drained", memx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
